// File: rtl/serial_bus_port.sv
// serial_bus_port: arbitrated MSB-first word serialiser and beat deserialiser; define SERIAL_PORT_RR_ARB_EN for round-robin arbitration (default fixed priority)
module serial_bus_port #(
  parameter int WORD_W = 16,
  parameter int BUS_W = 8,
  parameter int N_CH = 3,
  localparam int BEATS = WORD_W / BUS_W,
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        ch_req,
  input  logic [N_CH*WORD_W-1:0] ch_word,
  output logic [N_CH-1:0]        ch_grant,
  output logic [BUS_W-1:0]       out_bus,
  output logic                   data_out_ready,
  input  logic                   ard_receive_ready,
  output logic [CH_W-1:0]        out_ch,
  output logic                   shift_done,
  input  logic [BUS_W-1:0]       in_bus,
  input  logic                   data_in_ready,
  output logic [WORD_W-1:0]      rx_word,
  output logic                   rx_valid,
  output logic                   error
);
  localparam int BCW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [WORD_W-1:0] tx_sh, rx_sh, sel_word, rx_next;
  logic [BCW-1:0] tx_cnt, rx_cnt;
  logic [CH_W-1:0] sel, ch_r;
  logic found, send, tx_last, rx_last;
  if (WORD_W % BUS_W != 0 || BEATS < 1) begin : g_width_check
    $error("WORD_W must be a non-zero multiple of BUS_W");
  end
`ifdef SERIAL_PORT_RR_ARB_EN
  logic [CH_W-1:0] last;
  always_comb begin
    int best;
    best = N_CH;
    sel = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (ch_req[i] && ((i + N_CH - 1 - int'(last)) % N_CH) < best) begin
        best = (i + N_CH - 1 - int'(last)) % N_CH;
        sel = CH_W'(i);
      end
  end
`else
  always_comb begin
    sel = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (ch_req[i]) sel = CH_W'(i);
  end
`endif
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_CH; i++)
      if (sel == CH_W'(i)) sel_word = ch_word[i*WORD_W +: WORD_W];
  end
  assign found = |ch_req;
  assign send = state == SEND;
  assign tx_last = tx_cnt == BCW'(BEATS - 1);
  assign rx_last = rx_cnt == BCW'(BEATS - 1);
  assign rx_next = (rx_sh << BUS_W) | WORD_W'(in_bus);
  assign ch_grant = (!send && found && !rst) ? N_CH'(1) << sel : '0;
  assign out_bus = send ? tx_sh[WORD_W-1 -: BUS_W] : '0;
  assign out_ch = send ? ch_r : '0;
  assign data_out_ready = send;
  always_comb begin
    state_n = send ? ((ard_receive_ready && tx_last) ? IDLE : SEND) : (found ? SEND : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx_sh <= '0;
      tx_cnt <= '0;
      ch_r <= '0;
      shift_done <= 1'b0;
      error <= 1'b0;
      rx_sh <= '0;
      rx_cnt <= '0;
      rx_word <= '0;
      rx_valid <= 1'b0;
`ifdef SERIAL_PORT_RR_ARB_EN
      last <= '0;
`endif
    end else begin
      state <= state_n;
      shift_done <= send && ard_receive_ready && tx_last;
      error <= error | (ard_receive_ready && !send);
      rx_valid <= data_in_ready && rx_last;
      if (!send && found) begin
        tx_sh <= sel_word;
        ch_r <= sel;
        tx_cnt <= '0;
`ifdef SERIAL_PORT_RR_ARB_EN
        last <= sel;
`endif
      end else if (send && ard_receive_ready) begin
        tx_sh <= tx_sh << BUS_W;
        tx_cnt <= tx_cnt + 1'b1;
      end
      if (data_in_ready) begin
        rx_sh <= rx_next;
        rx_cnt <= rx_last ? '0 : rx_cnt + 1'b1;
        if (rx_last) rx_word <= rx_next;
      end
    end
  end
endmodule

// File: tb/tb_serial_bus_port.sv
// tb_serial_bus_port: directed stimulus with queued expectations checked by a negedge monitor
module tb_serial_bus_port;
  logic clk = 0, rst = 1;
  logic [2:0] ch_req = 0;
  logic [47:0] ch_word = 0;
  logic [2:0] ch_grant;
  logic [7:0] out_bus;
  logic data_out_ready;
  logic ard_receive_ready = 0;
  logic [1:0] out_ch;
  logic shift_done;
  logic [7:0] in_bus = 0;
  logic data_in_ready = 0;
  logic [15:0] rx_word;
  logic rx_valid, error;
  int cyc = 0, n_chk = 0, n_fail = 0;
  typedef struct {int c; logic [31:0] v;} exp_t;
  exp_t q_grant[$], q_beat[$], q_done[$], q_rx[$];
  serial_bus_port dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_word(ch_word), .ch_grant(ch_grant),
    .out_bus(out_bus), .data_out_ready(data_out_ready), .ard_receive_ready(ard_receive_ready),
    .out_ch(out_ch), .shift_done(shift_done), .in_bus(in_bus), .data_in_ready(data_in_ready),
    .rx_word(rx_word), .rx_valid(rx_valid), .error(error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push_beat(input int ch, input logic [7:0] b);
    q_beat.push_back('{cyc, 32'((ch << 8) | int'(b))});
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, 32'(ch_grant), 0);
    chk({tag, "_out_bus"}, 32'(out_bus), 0);
    chk({tag, "_dor"}, 32'(data_out_ready), 0);
    chk({tag, "_out_ch"}, 32'(out_ch), 0);
    chk({tag, "_done"}, 32'(shift_done), 0);
    chk({tag, "_rx_word"}, 32'(rx_word), 0);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask
  task automatic randomize_inputs();
    ch_req = 3'($urandom);
    ch_word = 48'({$urandom, $urandom});
    ard_receive_ready = 1'($urandom);
    in_bus = 8'($urandom);
    data_in_ready = 1'($urandom);
  endtask
  task automatic tx_word(input int ch, input logic [15:0] w, input int stall);
    logic [7:0] by;
    ch_req = 3'(1 << ch);
    ch_word[ch*16 +: 16] = w;
    ard_receive_ready = 0;
    q_grant.push_back('{cyc, 32'(1 << ch)});
    for (int b = 0; b < 2; b++) begin
      by = b == 0 ? w[15:8] : w[7:0];
      for (int s = 0; s < (b == 0 ? stall : 0); s++) begin
        step();
        ch_req = 0;
        ard_receive_ready = 0;
        push_beat(ch, by);
      end
      step();
      ch_req = 0;
      ard_receive_ready = 1;
      push_beat(ch, by);
    end
    step();
    ard_receive_ready = 0;
    q_done.push_back('{cyc, 0});
  endtask
  task automatic rx_seq();
    data_in_ready = 1; in_bus = 8'h12;
    step(); data_in_ready = 0;
    step(); data_in_ready = 1; in_bus = 8'h34; q_rx.push_back('{cyc + 1, 32'h1234});
    step(); in_bus = 8'h56;
    step(); in_bus = 8'h78; q_rx.push_back('{cyc + 1, 32'h5678});
    step(); in_bus = 8'h9A;
    step(); in_bus = 8'hBC; q_rx.push_back('{cyc + 1, 32'h9ABC});
    step(); data_in_ready = 0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (ch_grant != 0) begin
      if (q_grant.size() == 0) chk("grant_unexpected", 32'(ch_grant), 0);
      else begin
        e = q_grant.pop_front();
        chk("grant_cycle", cyc, e.c);
        chk("grant", 32'(ch_grant), e.v);
      end
    end
    if (data_out_ready === 1'b1) begin
      if (q_beat.size() == 0) chk("beat_unexpected", 32'(data_out_ready), 0);
      else begin
        e = q_beat.pop_front();
        chk("beat_cycle", cyc, e.c);
        chk("beat_ch_bus", 32'({out_ch, out_bus}), e.v);
      end
    end
    if (shift_done === 1'b1) begin
      if (q_done.size() == 0) chk("done_unexpected", 32'(shift_done), 0);
      else begin
        e = q_done.pop_front();
        chk("done_cycle", cyc, e.c);
      end
    end
    if (rx_valid === 1'b1) begin
      if (q_rx.size() == 0) chk("rx_unexpected", 32'(rx_valid), 0);
      else begin
        e = q_rx.pop_front();
        chk("rx_cycle", cyc, e.c);
        chk("rx_word", 32'(rx_word), e.v);
      end
    end
  end
  initial begin
    int ach;
    rst = 1;
    randomize_inputs();
    step(); randomize_inputs();
    @(negedge clk) chk_quiet("reset1");
    step(); randomize_inputs();
    @(negedge clk) chk_quiet("reset2");
    step();
    rst = 0; ch_req = 0; ch_word = 0; ard_receive_ready = 0; data_in_ready = 0; in_bus = 0;
    step();
    @(negedge clk) chk_quiet("post_reset");
    step();
    tx_word(1, 16'hBEEF, 0);
    tx_word(1, 16'hBEEF, 3);
    ch_word[15:0] = 16'hA1B2;
    ch_word[47:32] = 16'hC3D4;
    ch_req = 3'b101;
    for (int k = 0; k < 3; k++) begin
`ifdef SERIAL_PORT_RR_ARB_EN
      ach = k % 2 == 0 ? 2 : 0;
`else
      ach = 0;
`endif
      q_grant.push_back('{cyc, 32'(1 << ach)});
      step(); ard_receive_ready = 1; push_beat(ach, ach == 0 ? 8'hA1 : 8'hC3);
      step(); push_beat(ach, ach == 0 ? 8'hB2 : 8'hD4);
      step(); ard_receive_ready = 0; q_done.push_back('{cyc, 0});
      if (k == 2) ch_req = 0;
    end
    step();
    fork
      tx_word(1, 16'hBEEF, 0);
      rx_seq();
    join
    step(); ard_receive_ready = 1;
    @(negedge clk) chk("error_before_edge", 32'(error), 0);
    step(); ard_receive_ready = 0;
    @(negedge clk) chk("error_set", 32'(error), 1);
    step();
    tx_word(0, 16'h1357, 0);
    @(negedge clk) chk("error_sticky", 32'(error), 1);
    chk("rx_word_hold", 32'(rx_word), 32'h9ABC);
    step();
    ch_word[15:0] = 16'h2468; ch_req = 3'b001;
    q_grant.push_back('{cyc, 1});
    step(); ch_req = 0; ard_receive_ready = 1; push_beat(0, 8'h24);
    data_in_ready = 1; in_bus = 8'h11;
    step(); rst = 1; ard_receive_ready = 0; data_in_ready = 0; push_beat(0, 8'h68);
    step(); rst = 0;
    @(negedge clk);
    chk("midrst_error", 32'(error), 0);
    chk("midrst_dor", 32'(data_out_ready), 0);
    chk("midrst_done", 32'(shift_done), 0);
    step(); data_in_ready = 1; in_bus = 8'h22;
    step(); in_bus = 8'h33; q_rx.push_back('{cyc + 1, 32'h2233});
    step(); data_in_ready = 0;
    step();
    step();
    @(negedge clk);
    chk("grant_queue_left", q_grant.size(), 0);
    chk("beat_queue_left", q_beat.size(), 0);
    chk("done_queue_left", q_done.size(), 0);
    chk("rx_queue_left", q_rx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
